// File: rtl/i2c_target_pkg.sv
// Shared constants for the I2C responder: FSM state encodings and ACK/NACK bus levels.
package i2c_target_pkg;
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_ADDR     = 4'd1;
  localparam logic [3:0] S_ADDR_ACK = 4'd2;
  localparam logic [3:0] S_PTR      = 4'd3;
  localparam logic [3:0] S_PTR_ACK  = 4'd4;
  localparam logic [3:0] S_WR       = 4'd5;
  localparam logic [3:0] S_WR_ACK   = 4'd6;
  localparam logic [3:0] S_RD       = 4'd7;
  localparam logic [3:0] S_RD_ACK   = 4'd8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // bit counter values marking the ACK slot: 8 = byte shifted, 9 = ACK clock running
  localparam logic [3:0] BC_LAST = 4'd7;
  localparam logic [3:0] BC_BYTE = 4'd8;
  localparam logic [3:0] BC_ACK  = 4'd9;
endpackage

// File: rtl/i2c_target_line_filter.sv
// Pad conditioning for one I2C line: 2-FF synchronizer, FILT_LEN-sample glitch filter,
// and single-cycle rise/fall pulses aligned with the filtered level.
module i2c_line_filter #(
  parameter int FILT_LEN = 3   // must be >= 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt,
  output logic rise,
  output logic fall
);
  logic [1:0]          sync;
  logic [FILT_LEN-1:0] hist;

  // idle bus level is high, so everything resets to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      hist <= '1;
      filt <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      hist <= {hist[FILT_LEN-2:0], sync[1]};
      rise <= 1'b0;
      fall <= 1'b0;
      if (&hist && !filt) begin
        filt <= 1'b1;
        rise <= 1'b1;
      end else if (~|hist && filt) begin
        filt <= 1'b0;
        fall <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/i2c_target.sv
// I2C responder: 7-bit address, one-byte register pointer, auto-incrementing
// reads/writes against an external one-cycle strobe register interface.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'b1010_001,
  parameter int         ADDR_W      = 8,
  parameter int         FILT_LEN    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rst_n(rst_n), .raw(scl_i), .filt(scl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rst_n(rst_n), .raw(sda_i), .filt(sda), .rise(sda_rise), .fall(sda_fall)
  );

  logic start, stop;
  assign start = sda_fall & scl;
  assign stop  = sda_rise & scl;

  logic [3:0]        state;
  logic [7:0]        shreg;
  logic [3:0]        bitcnt;
  logic [ADDR_W-1:0] ptr;
  logic              rw, wr_pend, rd_lat;
  logic [7:0]        byte_in;

  assign byte_in = {shreg[6:0], sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      wr_pend   <= 1'b0;
      rd_lat    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= '0;
      reg_wr    <= 1'b0;
      reg_wdata <= '0;
      reg_rd    <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      rd_lat <= reg_rd;
      // read data arrives the cycle after the strobe; load it ahead of the next RD byte
      if (rd_lat) shreg <= reg_rdata;
      if (wr_pend) begin
        wr_pend   <= 1'b0;
        reg_wr    <= 1'b1;
        reg_addr  <= ptr;
        reg_wdata <= shreg;
        ptr       <= ptr + PTR_ONE;
      end

      if (start) begin
        state  <= S_ADDR;
        bitcnt <= '0;
        sda_oe <= 1'b0;
      end else if (stop) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_PTR, S_WR: if (scl_rise) begin
            shreg  <= byte_in;
            bitcnt <= bitcnt + 4'd1;
            if (bitcnt == BC_LAST) begin
              if (state == S_ADDR) begin
                if (byte_in[7:1] == DEVICE_ADDR) begin
                  busy  <= 1'b1;
                  rw    <= byte_in[0];
                  state <= S_ADDR_ACK;
                end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end
              end else if (state == S_PTR) begin
                ptr   <= ADDR_W'(byte_in);
                state <= S_PTR_ACK;
              end else begin
                wr_pend <= 1'b1;
                state   <= S_WR_ACK;
              end
            end
          end
          S_ADDR_ACK, S_PTR_ACK, S_WR_ACK: if (scl_fall) begin
            if (bitcnt == BC_BYTE) begin
              sda_oe <= ~ACK;
              bitcnt <= BC_ACK;
              if (state == S_ADDR_ACK && rw) begin
                reg_rd   <= 1'b1;
                reg_addr <= ptr;
              end
            end else begin
              bitcnt <= '0;
              if (state == S_ADDR_ACK && rw) begin
                state  <= S_RD;
                sda_oe <= ~shreg[7];
              end else begin
                sda_oe <= 1'b0;
                state  <= (state == S_ADDR_ACK) ? S_PTR : S_WR;
              end
            end
          end
          S_RD: begin
            if (scl_rise) bitcnt <= bitcnt + 4'd1;
            if (scl_fall) begin
              if (bitcnt == BC_BYTE) begin
                sda_oe <= 1'b0;
                state  <= S_RD_ACK;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              if (sda == ACK) begin
                ptr      <= ptr + PTR_ONE;
                reg_rd   <= 1'b1;
                reg_addr <= ptr + PTR_ONE;
                bitcnt   <= BC_ACK;
              end else begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end
            end else if (scl_fall && bitcnt == BC_ACK) begin
              state  <= S_RD;
              bitcnt <= '0;
              sda_oe <= ~shreg[7];
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, external register storage, and a
// byte-level memory model of the expected register contents.
module tb_i2c_target;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       scl_m = 1'b1, sda_m = 1'b1, scl_g = 1'b0, sda_g = 1'b0;
  logic       sda_oe, reg_wr, reg_rd, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       sda_bus, scl_i, sda_i;

  assign sda_bus = sda_m & ~sda_oe;
  assign scl_i   = scl_m ^ scl_g;
  assign sda_i   = sda_bus ^ sda_g;

  i2c_target dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #10 clk = ~clk;

  int vecs = 0, errs = 0;
  int q = 50;  // quarter SCL period in clk cycles
  logic [7:0]  dev_mem   [256];
  logic [7:0]  model_mem [256];
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];
  bit          both_seen = 0, busy_seen = 0;

  always @(posedge clk) begin
    if (reg_wr) begin
      dev_mem[reg_addr] <= reg_wdata;
      wr_q.push_back({reg_addr, reg_wdata});
    end
    if (reg_rd) begin
      reg_rdata <= dev_mem[reg_addr];
      rd_q.push_back(reg_addr);
    end
    if (reg_wr && reg_rd) both_seen = 1;
    if (busy) busy_seen = 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(q); scl_m = 1'b1; tick(q); sda_m = 1'b0; tick(q); scl_m = 1'b0; tick(q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(q); scl_m = 1'b1; tick(q); sda_m = 1'b1; tick(q);
  endtask

  task automatic clock_bit(input logic b, input bit g, output logic s);
    sda_m = b; tick(q); scl_m = 1'b1; tick(q);
    s = sda_bus;
    if (g) begin
      scl_g = 1'b1; tick(1); scl_g = 1'b0; tick(4);
      sda_g = 1'b1; tick(1); sda_g = 1'b0; tick(6);
      tick(q - 12);
    end else tick(q);
    scl_m = 1'b0; tick(q);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit g, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], g, s);
    clock_bit(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic ackb, input bit g, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin clock_bit(1'b1, g, s); b[i] = s; end
    clock_bit(ackb, 1'b0, s);
  endtask

  task automatic write_txn(input logic [7:0] ptr, input logic [7:0] d[$], input bit g, output int nacks);
    logic a;
    nacks = 0;
    i2c_start();
    send_byte(8'hA2, g, a); if (a) nacks++;
    send_byte(ptr, g, a);   if (a) nacks++;
    foreach (d[i]) begin send_byte(d[i], g, a); if (a) nacks++; end
    i2c_stop();
  endtask

  // leaves the bus right after the master's final NACK clock; caller issues STOP
  task automatic read_txn(input logic [7:0] ptr, input int n, input bit g,
                          output logic [7:0] d[$], output int nacks);
    logic a; logic [7:0] b;
    d = {}; nacks = 0;
    i2c_start();
    send_byte(8'hA2, g, a); if (a) nacks++;
    send_byte(ptr, g, a);   if (a) nacks++;
    i2c_start();
    send_byte(8'hA3, g, a); if (a) nacks++;
    for (int i = 0; i < n; i++) begin read_byte(i == n - 1, g, b); d.push_back(b); end
  endtask

  function automatic void model_write(input logic [7:0] ptr, input logic [7:0] d[$]);
    foreach (d[i]) model_mem[ptr + 8'(i)] = d[i];
  endfunction

  task automatic test_reset();
    tick(3);
    vecs++; if (sda_oe !== 1'b0) begin errs++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
    vecs++; if (reg_wr !== 1'b0 || reg_rd !== 1'b0) begin errs++; $display("FAIL reset_strobes: got wr=%b rd=%b want 0/0", reg_wr, reg_rd); end
    vecs++; if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin errs++; $display("FAIL reset_regs: got addr=%h wdata=%h want 00/00", reg_addr, reg_wdata); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick(10);
  endtask

  task automatic test_write();
    logic a; logic [7:0] d[$];
    logic [15:0] exp [$];
    d = '{8'h20, 8'h15};
    q = 50; wr_q.delete();
    i2c_start();
    send_byte(8'hA2, 0, a); vecs++; if (a !== 1'b0) begin errs++; $display("FAIL wr_ack_addr: got %b want 0", a); end
    send_byte(8'h02, 0, a); vecs++; if (a !== 1'b0) begin errs++; $display("FAIL wr_ack_ptr: got %b want 0", a); end
    foreach (d[i]) begin
      send_byte(d[i], 0, a); vecs++; if (a !== 1'b0) begin errs++; $display("FAIL wr_ack_data%0d: got %b want 0", i, a); end
    end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL wr_busy_before_stop: got %b want 1", busy); end
    i2c_stop(); tick(10);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL wr_busy_after_stop: got %b want 0", busy); end
    foreach (d[i]) exp.push_back({8'h02 + 8'(i), d[i]});
    model_write(8'h02, d);
    vecs++; if (wr_q !== exp) begin errs++; $display("FAIL wr_strobes: got %p want %p", wr_q, exp); end
    q = 20;
  endtask

  task automatic test_read();
    logic [7:0] d[$]; int nk;
    dev_mem[4] = 8'h16; dev_mem[5] = 8'h09;
    model_mem[4] = 8'h16; model_mem[5] = 8'h09;
    wr_q.delete(); rd_q.delete();
    read_txn(8'h04, 2, 0, d, nk);
    vecs++; if (nk !== 0) begin errs++; $display("FAIL rd_acks: got %0d nacks want 0", nk); end
    vecs++; if (d.size() != 2 || d[0] !== model_mem[4] || d[1] !== model_mem[5]) begin errs++; $display("FAIL rd_data: got %p want 16 09", d); end
    vecs++; if (rd_q.size() != 2 || rd_q[0] !== 8'h04 || rd_q[1] !== 8'h05) begin errs++; $display("FAIL rd_addrs: got %p want 04 05", rd_q); end
    vecs++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rd_release: got oe=%b busy=%b want 0/0", sda_oe, busy); end
    vecs++; if (wr_q.size() != 0) begin errs++; $display("FAIL rd_no_wr: got %0d writes want 0", wr_q.size()); end
    i2c_stop(); tick(10);
  endtask

  task automatic test_mismatch();
    logic a, a2;
    wr_q.delete(); rd_q.delete(); busy_seen = 0;
    i2c_start();
    send_byte(8'hA0, 0, a);
    send_byte(8'h00, 0, a2);
    send_byte(8'h55, 0, a2);
    i2c_stop(); tick(10);
    vecs++; if (a !== 1'b1) begin errs++; $display("FAIL mm_nack: got %b want 1", a); end
    vecs++; if (busy_seen !== 1'b0) begin errs++; $display("FAIL mm_busy: got busy seen want never"); end
    vecs++; if (wr_q.size() != 0 || rd_q.size() != 0) begin errs++; $display("FAIL mm_strobes: got wr=%0d rd=%0d want 0/0", wr_q.size(), rd_q.size()); end
  endtask

  task automatic test_wrap();
    logic [7:0] d[$]; int nk;
    logic [15:0] exp [$];
    d = '{8'hAA, 8'hBB};
    wr_q.delete();
    write_txn(8'hFF, d, 0, nk); tick(10);
    foreach (d[i]) exp.push_back({8'hFF + 8'(i), d[i]});
    model_write(8'hFF, d);
    vecs++; if (nk !== 0) begin errs++; $display("FAIL wrap_acks: got %0d nacks want 0", nk); end
    vecs++; if (wr_q !== exp) begin errs++; $display("FAIL wrap_strobes: got %p want %p", wr_q, exp); end
  endtask

  task automatic test_partial_stop();
    logic a, s;
    wr_q.delete();
    i2c_start();
    send_byte(8'hA2, 0, a);
    send_byte(8'h10, 0, a);
    for (int i = 0; i < 4; i++) clock_bit(i[0], 0, s);
    i2c_stop(); tick(10);
    vecs++; if (wr_q.size() != 0) begin errs++; $display("FAIL partial_no_wr: got %0d writes want 0", wr_q.size()); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL partial_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d[$]; int nk; logic a;
    d = '{8'h3C};
    write_txn(8'h30, d, 0, nk); model_write(8'h30, d); tick(10);
    i2c_start();
    send_byte(8'hA2, 0, a); send_byte(8'h30, 0, a);
    i2c_start();
    send_byte(8'hA3, 0, a);
    vecs++; if (sda_oe !== ~model_mem[8'h30][7]) begin errs++; $display("FAIL rst_drive_bit: got oe=%b want %b", sda_oe, ~model_mem[8'h30][7]); end
    #3 rst_n = 1'b0;
    #1;
    vecs++; if (sda_oe !== 1'b0) begin errs++; $display("FAIL rst_async_release: got oe=%b want 0", sda_oe); end
    tick(2); rst_n = 1'b1; tick(5);
    i2c_stop(); tick(10);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    logic [7:0] d[$], r[$]; int nk;
    logic [15:0] exp [$];
    logic [7:0] ptr;
    ptr = 8'($urandom_range(0, 255));
    d = '{8'($urandom), 8'($urandom)};
    wr_q.delete();
    write_txn(ptr, d, 1, nk); tick(10);
    foreach (d[i]) exp.push_back({ptr + 8'(i), d[i]});
    model_write(ptr, d);
    vecs++; if (nk !== 0) begin errs++; $display("FAIL glitch_wr_acks: got %0d nacks want 0", nk); end
    vecs++; if (wr_q !== exp) begin errs++; $display("FAIL glitch_wr: got %p want %p", wr_q, exp); end
    read_txn(ptr, 2, 1, r, nk); i2c_stop(); tick(10);
    vecs++; if (nk !== 0 || r.size() != 2 || r[0] !== model_mem[ptr] || r[1] !== model_mem[ptr + 8'd1]) begin
      errs++; $display("FAIL glitch_rd: got %p nacks=%0d want %h %h", r, nk, model_mem[ptr], model_mem[ptr + 8'd1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[$], r[$], ptr; int n, nk;
    logic [15:0] exp [$];
    for (int it = 0; it < 3; it++) begin
      ptr = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      d = {}; exp = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      wr_q.delete(); rd_q.delete();
      write_txn(ptr, d, 0, nk); tick(10);
      foreach (d[i]) exp.push_back({ptr + 8'(i), d[i]});
      model_write(ptr, d);
      vecs++; if (nk !== 0 || wr_q !== exp) begin errs++; $display("FAIL b2b_wr%0d: got %p nacks=%0d want %p", it, wr_q, nk, exp); end
      read_txn(ptr, n, 0, r, nk); i2c_stop(); tick(10);
      for (int i = 0; i < n; i++) begin
        vecs++;
        if (r[i] !== model_mem[ptr + 8'(i)] || rd_q[i] !== ptr + 8'(i)) begin
          errs++; $display("FAIL b2b_rd%0d_%0d: got data=%h addr=%h want %h/%h", it, i, r[i], rd_q[i], model_mem[ptr + 8'(i)], ptr + 8'(i));
        end
      end
      vecs++; if (nk !== 0 || rd_q.size() != n) begin errs++; $display("FAIL b2b_rdcnt%0d: got %0d reads nacks=%0d want %0d", it, rd_q.size(), nk, n); end
    end
    vecs++; if (both_seen !== 1'b0) begin errs++; $display("FAIL wr_rd_overlap: got overlap want none"); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin dev_mem[i] = 8'h00; model_mem[i] = 8'h00; end
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_wrap();
    test_partial_stop();
    test_reset_mid_read();
    test_glitch();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
